sign_narrow_sat: RTL and testbench

Streaming signed narrower: accepts signed IN_W-bit samples over a valid/ready handshake and emits OUT_W-bit signed samples, saturating (or wrapping) values that do not fit. It is the inverse of the datapath's sign-extension stage, returning widened adder results to the 8-bit domain. Each output carries a per-sample overflow flag, and a sticky saturating counter tracks overflow events for status readout.

---
 rtl/sign_narrow_sat_if.sv | 31 +++
 rtl/sign_narrow_sat.sv | 131 +++++++++++++
 tb/tb_sign_narrow_sat.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/sign_narrow_sat_if.sv
// Stream bundle for sign_narrow_sat: the upstream sample handshake and the
// downstream narrowed-sample handshake, grouped so the block's port list
// stays short and the direction of every signal is fixed by a modport.
interface sign_narrow_sat_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8
);
  // Upstream side: wide signed samples plus the per-sample overflow policy.
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             sat_en;

  // Downstream side: narrowed sample and its overflow flag.
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_ovf;

  // Environment view: produces samples and consumes narrowed results.
  modport master (
    output in_valid, in_data, sat_en, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  // Block view: consumes samples and produces narrowed results.
  modport slave (
    input  in_valid, in_data, sat_en, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/sign_narrow_sat.sv
// Streaming signed narrower. Converts IN_W-bit two's complement samples to
// OUT_W bits, either saturating to the nearest representable extreme or
// wrapping (dropping high bits) when a sample does not fit. A single output
// register gives full throughput; a sticky saturating counter records how
// many overflowed samples were accepted since reset or the last clear.
module sign_narrow_sat #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  sign_narrow_sat_if.slave  bus,
  input  logic              cnt_clr_i,
  output logic [CNT_W-1:0]  ovf_count_o
);

  // Narrowing only makes sense when the output is strictly smaller and has
  // room for a sign bit plus at least one magnitude bit.
  if (OUT_W < 2 || OUT_W >= IN_W) begin : g_bad_params
    $error("sign_narrow_sat: need 2 <= OUT_W < IN_W");
  end

  // ---------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------
  logic                accept;
  logic [IN_W-OUT_W:0] upper_bits;   // sign bit of the result and everything above it
  logic                fit;
  logic                ovf;
  logic [OUT_W-1:0]    sat_data;
  logic [OUT_W-1:0]    narrow_data;

  logic                out_valid_q, out_valid_d;
  logic [OUT_W-1:0]    out_data_q,  out_data_d;
  logic                out_ovf_q,   out_ovf_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;

  // ---------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------
  // Ready depends only on register state and out_ready, never on in_valid,
  // so no combinational loop can form through an upstream that waits on ready.
  assign bus.in_ready = ~out_valid_q | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;

  // ---------------------------------------------------------------------
  // Fit test and result selection
  // ---------------------------------------------------------------------
  // The sample fits when the bits from the output sign position upward are
  // all copies of one value, i.e. the sample is the sign extension of its
  // low OUT_W bits.
  assign upper_bits = bus.in_data[IN_W-1:OUT_W-1];

  // Choose between the truncated value and the saturation extreme.
  always_comb begin
    fit         = (&upper_bits) | ~(|upper_bits);
    ovf         = ~fit;
    // Positive overflow clamps to the largest positive code, negative to the
    // most negative code; the input's own sign bit tells which side.
    sat_data    = bus.in_data[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                      : {1'b0, {(OUT_W-1){1'b1}}};
    // Wrap mode and in-range samples both take the low bits unchanged.
    narrow_data = (ovf && bus.sat_en) ? sat_data : bus.in_data[OUT_W-1:0];
  end

  // ---------------------------------------------------------------------
  // Output register next state
  // ---------------------------------------------------------------------
  // Load on accept; otherwise drop valid once the consumer has taken it.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    if (accept) begin
      // Covers the drain-and-refill case too: the register is replaced in
      // the same edge the consumer takes the old sample, with no bubble.
      out_valid_d = 1'b1;
      out_data_d  = narrow_data;
      out_ovf_d   = ovf;
    end else if (bus.out_ready) begin
      // Data and flag keep their last value; only valid is withdrawn.
      out_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Overflow counter next state
  // ---------------------------------------------------------------------
  // Sticky count of overflowed accepts; clear beats a same-cycle increment.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (accept && ovf && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  // Synchronous reset empties the output register and zeroes the counter;
  // a sample held at reset is discarded, not replayed.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      cnt_q       <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;
  assign ovf_count_o   = cnt_q;

endmodule

// File: tb/tb_sign_narrow_sat.sv
// Bench for sign_narrow_sat. Two instances share all stream inputs: one with
// the default 16-bit counter and one with a 2-bit counter, so counter
// saturation is visible on every scenario. Expected values come from a
// behavioural model that works on integer sample values.
module tb_sign_narrow_sat;

  logic clk = 1'b0;
  logic rst;
  logic cnt_clr;
  logic [15:0] cnt16;
  logic [1:0]  cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sign_narrow_sat_if #(.IN_W(16), .OUT_W(8)) u_if ();
  sign_narrow_sat_if #(.IN_W(16), .OUT_W(8)) u_if2 ();

  assign u_if2.in_valid  = u_if.in_valid;
  assign u_if2.in_data   = u_if.in_data;
  assign u_if2.sat_en    = u_if.sat_en;
  assign u_if2.out_ready = u_if.out_ready;

  sign_narrow_sat #(.IN_W(16), .OUT_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(u_if.slave),
    .cnt_clr_i(cnt_clr), .ovf_count_o(cnt16)
  );

  sign_narrow_sat #(.IN_W(16), .OUT_W(8), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .bus(u_if2.slave),
    .cnt_clr_i(cnt_clr), .ovf_count_o(cnt2)
  );

  // ---------------- reference model (integer arithmetic) ----------------
  function automatic bit ref_ovf(input logic [15:0] d);
    int v;
    v = int'($signed(d));
    return (v > 127) || (v < -128);
  endfunction

  function automatic logic [7:0] ref_data(input logic [15:0] d, input logic s);
    int v;
    v = int'($signed(d));
    if (s && v > 127)  return 8'h7F;
    if (s && v < -128) return 8'h80;
    return 8'(v);   // value modulo 256
  endfunction

  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ovf;
  int         m_cnt, m_cnt2;
  wire        m_ready = !m_valid || u_if.out_ready;
  wire        m_acc   = u_if.in_valid && m_ready;

  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0; m_data <= 8'h00; m_ovf <= 1'b0; m_cnt <= 0; m_cnt2 <= 0;
    end else begin
      if (m_acc) begin
        m_valid <= 1'b1;
        m_data  <= ref_data(u_if.in_data, u_if.sat_en);
        m_ovf   <= ref_ovf(u_if.in_data);
      end else if (u_if.out_ready) begin
        m_valid <= 1'b0;
      end
      if (cnt_clr) begin
        m_cnt <= 0; m_cnt2 <= 0;
      end else if (m_acc && ref_ovf(u_if.in_data)) begin
        m_cnt  <= (m_cnt  >= 65535) ? 65535 : m_cnt + 1;
        m_cnt2 <= (m_cnt2 >= 3)     ? 3     : m_cnt2 + 1;
      end
    end
  end

  // ---------------- directed tables ----------------
  logic [15:0] t_in  [10] = '{16'h007F, 16'hFF80, 16'h0000, 16'hFFFF,
                              16'h0080, 16'h7FFF, 16'hFF7F, 16'h8000,
                              16'h0180, 16'hFE7F};
  logic [7:0]  t_out [10] = '{8'h7F, 8'h80, 8'h00, 8'hFF,
                              8'h7F, 8'h7F, 8'h80, 8'h80,
                              8'h80, 8'h7F};
  logic        t_ovf [10] = '{1'b0, 1'b0, 1'b0, 1'b0,
                              1'b1, 1'b1, 1'b1, 1'b1,
                              1'b1, 1'b1};

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; cnt_clr = 1'b0;
    u_if.in_valid = 1'b1; u_if.in_data = 16'h7FFF; u_if.sat_en = 1'b1; u_if.out_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      n_checks++; if (u_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", u_if.out_valid); end
      n_checks++; if (u_if.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h want 00", u_if.out_data); end
      n_checks++; if (cnt16 !== 16'd0 || cnt2 !== 2'd0) begin n_fail++; $display("FAIL reset_count: got %0d/%0d want 0/0", cnt16, cnt2); end
    end
    rst = 1'b0; u_if.in_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (u_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", u_if.in_ready); end
    n_checks++; if (u_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_idle_valid: got %b want 0", u_if.out_valid); end
  endtask

  // Fit boundaries, saturation and wrap at full rate with out_ready held high.
  task automatic test_narrow();
    int ec = 0;
    int ec2;
    u_if.out_ready = 1'b1; cnt_clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      u_if.in_valid = 1'b1; u_if.in_data = t_in[i]; u_if.sat_en = (i < 8);
      #1;
      n_checks++; if (u_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL narrow_in_ready[%0d]: got %b want 1", i, u_if.in_ready); end
      @(posedge clk); #1;
      if (t_ovf[i]) ec++;
      ec2 = (ec > 3) ? 3 : ec;
      n_checks++; if (u_if.out_valid !== 1'b1) begin n_fail++; $display("FAIL narrow_valid[%0d]: got %b want 1", i, u_if.out_valid); end
      n_checks++; if (u_if.out_data !== t_out[i]) begin n_fail++; $display("FAIL narrow_data[%0d] in=%h: got %h want %h", i, t_in[i], u_if.out_data, t_out[i]); end
      n_checks++; if (u_if.out_ovf !== t_ovf[i]) begin n_fail++; $display("FAIL narrow_ovf[%0d]: got %b want %b", i, u_if.out_ovf, t_ovf[i]); end
      n_checks++; if (cnt16 !== 16'(ec)) begin n_fail++; $display("FAIL narrow_count[%0d]: got %0d want %0d", i, cnt16, ec); end
      n_checks++; if (cnt2 !== 2'(ec2)) begin n_fail++; $display("FAIL narrow_count2[%0d]: got %0d want %0d", i, cnt2, ec2); end
    end
    u_if.in_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (u_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %b want 0", u_if.out_valid); end
    n_checks++; if (u_if.out_data !== 8'h7F) begin n_fail++; $display("FAIL drain_data_retained: got %h want 7f", u_if.out_data); end
  endtask

  // Stream 1..5 with a three-cycle consumer stall in the middle.
  task automatic test_backpressure();
    logic [7:0] got[$];
    int idx = 1;
    for (int cyc = 0; cyc < 40 && got.size() < 5; cyc++) begin
      u_if.out_ready = !(cyc >= 3 && cyc < 6);
      u_if.in_valid  = (idx <= 5);
      u_if.in_data   = 16'(idx);
      u_if.sat_en    = 1'b1;
      #1;
      n_checks++; if (u_if.in_ready !== m_ready) begin n_fail++; $display("FAIL bp_in_ready[c%0d]: got %b want %b", cyc, u_if.in_ready, m_ready); end
      if (u_if.out_valid && u_if.out_ready) got.push_back(u_if.out_data);
      if (m_acc) idx++;
      @(posedge clk); #1;
      n_checks++; if (u_if.out_valid !== m_valid || u_if.out_data !== m_data) begin
        n_fail++; $display("FAIL bp_out[c%0d]: got v=%b d=%h want v=%b d=%h", cyc, u_if.out_valid, u_if.out_data, m_valid, m_data);
      end
    end
    u_if.in_valid = 1'b0;
    n_checks++; if (got.size() != 5) begin n_fail++; $display("FAIL bp_count: got %0d samples want 5", got.size()); end
    for (int i = 0; i < got.size() && i < 5; i++) begin
      n_checks++; if (got[i] !== 8'(i + 1)) begin n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", i, got[i], 8'(i + 1)); end
    end
  endtask

  // Counter saturation and clear-versus-increment priority.
  task automatic test_counter();
    u_if.out_ready = 1'b1; u_if.sat_en = 1'b1; u_if.in_valid = 1'b0;
    cnt_clr = 1'b1; #1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    n_checks++; if (cnt16 !== 16'd0 || cnt2 !== 2'd0) begin n_fail++; $display("FAIL cnt_clear_idle: got %0d/%0d want 0/0", cnt16, cnt2); end
    for (int i = 1; i <= 5; i++) begin
      u_if.in_valid = 1'b1; u_if.in_data = 16'h4000; #1;
      @(posedge clk); #1;
      n_checks++; if (cnt16 !== 16'(i)) begin n_fail++; $display("FAIL cnt_inc[%0d]: got %0d want %0d", i, cnt16, i); end
      n_checks++; if (cnt2 !== 2'((i > 3) ? 3 : i)) begin n_fail++; $display("FAIL cnt_sat[%0d]: got %0d want %0d", i, cnt2, (i > 3) ? 3 : i); end
    end
    cnt_clr = 1'b1; u_if.in_data = 16'h8000; #1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    n_checks++; if (u_if.out_ovf !== 1'b1 || u_if.out_data !== 8'h80) begin n_fail++; $display("FAIL clr_ovf_sample: got ovf=%b d=%h want ovf=1 d=80", u_if.out_ovf, u_if.out_data); end
    n_checks++; if (cnt16 !== 16'd0 || cnt2 !== 2'd0) begin n_fail++; $display("FAIL clr_wins: got %0d/%0d want 0/0", cnt16, cnt2); end
    u_if.in_data = 16'h0100; #1;
    @(posedge clk); #1;
    n_checks++; if (cnt16 !== 16'd1 || cnt2 !== 2'd1) begin n_fail++; $display("FAIL cnt_after_clr: got %0d/%0d want 1/1", cnt16, cnt2); end
    u_if.in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // Random traffic, boundary-biased data, random stalls, clears and resets.
  task automatic test_random();
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst           = ($urandom_range(0, 149) == 0);
      cnt_clr       = ($urandom_range(0, 19) == 0);
      u_if.in_valid = ($urandom_range(0, 3) != 0);
      u_if.sat_en   = $urandom_range(0, 1) != 0;
      u_if.out_ready = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 3))
        0:       u_if.in_data = 16'($urandom);
        1:       u_if.in_data = 16'($urandom_range(0, 511)) - 16'd256;
        2:       u_if.in_data = 16'h7FF0 + 16'($urandom_range(0, 15));
        default: u_if.in_data = 16'h8000 + 16'($urandom_range(0, 15));
      endcase
      #1;
      n_checks++; if (u_if.in_ready !== m_ready) begin n_fail++; $display("FAIL rnd_in_ready[c%0d]: got %b want %b", cyc, u_if.in_ready, m_ready); end
      @(posedge clk); #1;
      n_checks++; if (u_if.out_valid !== m_valid || u_if.out_data !== m_data || u_if.out_ovf !== m_ovf) begin
        n_fail++; $display("FAIL rnd_out[c%0d]: got v=%b d=%h o=%b want v=%b d=%h o=%b", cyc,
                           u_if.out_valid, u_if.out_data, u_if.out_ovf, m_valid, m_data, m_ovf);
      end
      n_checks++; if (u_if2.out_data !== m_data) begin n_fail++; $display("FAIL rnd_small_data[c%0d]: got %h want %h", cyc, u_if2.out_data, m_data); end
      n_checks++; if (cnt16 !== 16'(m_cnt) || cnt2 !== 2'(m_cnt2)) begin
        n_fail++; $display("FAIL rnd_count[c%0d]: got %0d/%0d want %0d/%0d", cyc, cnt16, cnt2, m_cnt, m_cnt2);
      end
    end
    rst = 1'b0; cnt_clr = 1'b0; u_if.in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cnt_clr = 1'b0;
    u_if.in_valid = 1'b0; u_if.in_data = '0; u_if.sat_en = 1'b0; u_if.out_ready = 1'b0;
    test_reset();
    test_narrow();
    test_backpressure();
    test_counter();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
